wb_req_bridge: RTL and testbench



---
 rtl/wb_req_bridge_pkg.sv | 26 ++
 rtl/wb_req_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_wb_req_bridge.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_req_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-request bridge.
// Holds the FSM state encoding, the timeout fill pattern and the address shift.
// Imported by wb_req_bridge; contains no logic of its own.
package wb_req_pkg;

    // ST_ERR is only reachable when the read timeout is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RWAIT = 3'd3,
        ST_ACK   = 3'd4,
        ST_ERR   = 3'd5
    } wb_req_state_t;

    // Returned on dat_o when a read gives up waiting for its data beat.
    localparam logic [31:0] WB_REQ_TIMEOUT_DATA = 32'hDEADBEEF;

    // Wishbone carries word addresses; the request side wants byte addresses.
    localparam int WB_REQ_ADDR_LSB = 2;

    function automatic logic [31:0] wb_req_byte_addr(input logic [29:0] word_adr);
        return {word_adr, {WB_REQ_ADDR_LSB{1'b0}}};
    endfunction

endpackage : wb_req_pkg

// File: rtl/wb_req_bridge.sv
// Wishbone classic slave turning each single-beat cycle into one req/write/read transaction.
// Latency: write ack 3 cycles after stb with req_ready high; read ack 1 cycle after read_valid.
// Backpressure: req_ready stalls hold REQ with fields stable; write beats are always accepted.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   cyc_i/stb_i/we_i/sel_i/adr_i/dat_i, ack_o/dat_o[/err_o]   Wishbone slave side
//   req_valid/req_ready/req_len/req_mask/req_addr/req_we/req_wrap  request channel
//   write_valid/write_data       posted write beat
//   read_valid/read_ack/read_data  read beat
//
// Build option: define WB_REQ_TIMEOUT_EN to add the read timeout, the ERR state and err_o.
module wb_req_bridge
    import wb_req_pkg::*;
#(
    parameter int unsigned LW      = 3,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    // Wishbone slave
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic          we_i,
    input  logic [3:0]    sel_i,
    input  logic [29:0]   adr_i,
    input  logic [31:0]   dat_i,
    output logic          ack_o,
    output logic [31:0]   dat_o,
`ifdef WB_REQ_TIMEOUT_EN
    output logic          err_o,
`endif
    // Request channel
    output logic          req_valid,
    input  logic          req_ready,
    output logic [LW-1:0] req_len,
    output logic [3:0]    req_mask,
    output logic [31:0]   req_addr,
    output logic          req_we,
    output logic          req_wrap,
    // Write beat
    output logic          write_valid,
    output logic [31:0]   write_data,
    // Read beat
    input  logic          read_valid,
    output logic          read_ack,
    input  logic [31:0]   read_data
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_req_bridge: TIMEOUT must be at least 2");
    end

    wb_req_state_t state_q, state_d;

    logic [31:0] req_addr_q, req_addr_d;
    logic [3:0]  req_mask_q, req_mask_d;
    logic        req_we_q, req_we_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] dat_o_q, dat_o_d;
    // Set when the master drops cyc_i mid-transaction; suppresses ack/err.
    logic        aborted_q, aborted_d;

    logic        stale;       // a timed-out read beat may still arrive
    logic        rd_timeout;  // RWAIT has waited its full budget this cycle
    logic        wb_start;
    logic        in_flight;

    assign wb_start  = (state_q == ST_IDLE) && cyc_i && stb_i && !stale;
    assign in_flight = (state_q == ST_REQ) || (state_q == ST_WDATA) || (state_q == ST_RWAIT);

`ifdef WB_REQ_TIMEOUT_EN
    // Counts RWAIT cycles without a data beat; hits at TIMEOUT-1 so that
    // RWAIT lasts exactly TIMEOUT cycles before ERR.
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stale_q, stale_d;

    assign rd_timeout = (state_q == ST_RWAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign stale      = stale_q;

    always_comb begin
        cnt_d   = '0;
        stale_d = stale_q;
        if ((state_q == ST_RWAIT) && !read_valid) begin
            cnt_d = cnt_q + 1'b1;
        end
        // The abandoned beat is swallowed by the first read_valid after ERR.
        if (state_q == ST_ERR) begin
            stale_d = 1'b1;
        end else if (stale_q && read_valid) begin
            stale_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
        end
    end
`else
    assign rd_timeout = 1'b0;
    assign stale      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // An all-zero byte select touches nothing: acknowledge locally.
                if (wb_start) begin
                    state_d = (sel_i == 4'h0) ? ST_ACK : ST_REQ;
                end
            end
            ST_REQ: begin
                if (req_ready) begin
                    state_d = req_we_q ? ST_WDATA : ST_RWAIT;
                end
            end
            ST_WDATA: state_d = ST_ACK;
            ST_RWAIT: begin
                if (read_valid) begin
                    state_d = ST_ACK;
                end else if (rd_timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (Moore, except read_ack which follows read_valid)
    // ------------------------------------------------------------------
    always_comb begin
        req_valid   = (state_q == ST_REQ);
        write_valid = (state_q == ST_WDATA);
        ack_o       = (state_q == ST_ACK) && !aborted_q;
        read_ack    = read_valid && ((state_q == ST_RWAIT) || stale);
`ifdef WB_REQ_TIMEOUT_EN
        err_o       = (state_q == ST_ERR) && !aborted_q;
`endif
    end

    // ------------------------------------------------------------------
    // Captured request fields and read data
    // ------------------------------------------------------------------
    always_comb begin
        req_addr_d   = req_addr_q;
        req_mask_d   = req_mask_q;
        req_we_d     = req_we_q;
        write_data_d = write_data_q;
        dat_o_d      = dat_o_q;
        aborted_d    = aborted_q;

        if (wb_start) begin
            req_addr_d   = wb_req_byte_addr(adr_i);
            req_mask_d   = sel_i;
            req_we_d     = we_i;
            write_data_d = dat_i;
            aborted_d    = 1'b0;
        end

        // The request side still runs to completion; only the Wishbone
        // response is dropped.
        if (in_flight && !cyc_i) begin
            aborted_d = 1'b1;
        end

        if (state_q == ST_RWAIT) begin
            if (read_valid) begin
                dat_o_d = read_data;
            end else if (rd_timeout) begin
                dat_o_d = WB_REQ_TIMEOUT_DATA;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_addr_q   <= '0;
            req_mask_q   <= '0;
            req_we_q     <= 1'b0;
            write_data_q <= '0;
            dat_o_q      <= '0;
            aborted_q    <= 1'b0;
        end else begin
            req_addr_q   <= req_addr_d;
            req_mask_q   <= req_mask_d;
            req_we_q     <= req_we_d;
            write_data_q <= write_data_d;
            dat_o_q      <= dat_o_d;
            aborted_q    <= aborted_d;
        end
    end

    assign req_addr   = req_addr_q;
    assign req_mask   = req_mask_q;
    assign req_we     = req_we_q;
    assign req_len    = '0;
    assign req_wrap   = 1'b0;
    assign write_data = write_data_q;
    assign dat_o      = dat_o_q;

endmodule : wb_req_bridge

// File: tb/tb_wb_req_bridge.sv
// Testbench for wb_req_bridge: directed cases plus randomized transactions
// checked against cycle-count rules and a remembered last-read value.
module tb_wb_req_bridge;

    localparam int LW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cyc_i, stb_i, we_i;
    logic [3:0]    sel_i;
    logic [29:0]   adr_i;
    logic [31:0]   dat_i;
    logic          ack_o;
    logic [31:0]   dat_o;
`ifdef WB_REQ_TIMEOUT_EN
    logic          err_o;
`endif
    logic          req_valid, req_ready;
    logic [LW-1:0] req_len;
    logic [3:0]    req_mask;
    logic [31:0]   req_addr;
    logic          req_we, req_wrap;
    logic          write_valid;
    logic [31:0]   write_data;
    logic          read_valid, read_ack;
    logic [31:0]   read_data;

    wb_req_bridge #(.LW(LW), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i),
        .adr_i(adr_i), .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o),
`ifdef WB_REQ_TIMEOUT_EN
        .err_o(err_o),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
        .req_mask(req_mask), .req_addr(req_addr), .req_we(req_we), .req_wrap(req_wrap),
        .write_valid(write_valid), .write_data(write_data),
        .read_valid(read_valid), .read_ack(read_ack), .read_data(read_data)
    );

    always #5 clk_i = ~clk_i;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] last_rd;   // model of what dat_o must be holding

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            chk("idle_ack", 32'(ack_o), 32'd0);
            chk("idle_req_valid", 32'(req_valid), 32'd0);
            step();
        end
    endtask

    // One Wishbone cycle. Expected ack cycle (stb first seen = cycle 0):
    //   sel==0 -> 1;  write -> 1 + stalls + 2;  read -> handshake + rdly + 1,
    // with the handshake in cycle 1 + stalls and read_valid rdly cycles later.
    task automatic run_txn(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input int stalls, input int rdly,
                           input logic [31:0] rdat);
        int hs       = 1 + stalls;
        int exp_ack  = (sel == 4'h0) ? 1 : (we ? hs + 2 : hs + rdly + 1);
        int exp_req  = (sel == 4'h0) ? 0 : stalls + 1;
        int exp_wv   = (we && sel != 4'h0) ? 1 : 0;
        int ack_cyc  = -1;
        int rq_cnt   = 0;
        int wv_cnt   = 0;
        logic [31:0] ack_dat = 32'h0;
        logic [31:0] exp_addr = 32'(adr) * 4;

        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; sel_i = sel; adr_i = adr; dat_i = dat;
        for (int c = 0; c < 40; c++) begin
            req_ready  = (c >= hs);
            read_valid = (!we && sel != 4'h0 && c == hs + rdly);
            read_data  = read_valid ? rdat : $urandom;
            @(negedge clk_i);
            if (req_valid) begin
                rq_cnt++;
                chk("req_addr", req_addr, exp_addr);
                chk("req_mask", 32'(req_mask), 32'(sel));
                chk("req_we", 32'(req_we), 32'(we));
                chk("req_len", 32'(req_len), 32'd0);
                chk("req_wrap", 32'(req_wrap), 32'd0);
            end
            if (write_valid) begin
                wv_cnt++;
                chk("write_data", write_data, dat);
            end
            if (read_valid) chk("read_ack", 32'(read_ack), 32'd1);
            if (ack_o) begin
                ack_cyc = c;
                ack_dat = dat_o;
            end
            step();
            if (ack_cyc >= 0) break;
        end
        cyc_i = 1'b0; stb_i = 1'b0; req_ready = 1'b0; read_valid = 1'b0;

        chk("ack_cycle", ack_cyc, exp_ack);
        chk("req_beats", rq_cnt, exp_req);
        chk("write_beats", wv_cnt, exp_wv);
        if (!we && sel != 4'h0) last_rd = rdat;
        chk("dat_o_at_ack", ack_dat, last_rd);
        idle_cycles(1);
    endtask

    initial begin
        int ack_seen;
        rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = 4'h0;
        adr_i = '0; dat_i = '0; req_ready = 1'b0; read_valid = 1'b0; read_data = '0;
        last_rd = 32'h0;

        // Reset values
        #2 rst_i = 1'b0;
        #1;
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_write_valid", 32'(write_valid), 32'd0);
        chk("rst_read_ack", 32'(read_ack), 32'd0);
        chk("rst_dat_o", dat_o, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_req_addr", req_addr, 32'd0);
        chk("rst_req_mask", 32'(req_mask), 32'd0);
        chk("rst_req_we", 32'(req_we), 32'd0);
        chk("rst_req_len", 32'(req_len), 32'd0);
        chk("rst_req_wrap", 32'(req_wrap), 32'd0);
`ifdef WB_REQ_TIMEOUT_EN
        chk("rst_err", 32'(err_o), 32'd0);
`endif
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_i = 1'b1;
        step();
        idle_cycles(1);

        // Directed: full-mask write, read with stalls, zero-select write
        run_txn(1'b1, 30'h100, 4'hF, 32'hCAFEF00D, 0, 1, 32'h0);
        run_txn(1'b0, 30'h8,   4'hF, 32'h0,        3, 5, 32'h12345678);
        run_txn(1'b1, 30'h20,  4'h0, 32'h55AA55AA, 0, 1, 32'h0);

        // Abort: master drops cyc_i while the read is outstanding
        ack_seen = 0;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; adr_i = 30'h55; req_ready = 1'b1;
        step();
        @(negedge clk_i);
        chk("abort_req_valid", 32'(req_valid), 32'd1);
        step();
        cyc_i = 1'b0; stb_i = 1'b0; req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (ack_o) ack_seen++;
            step();
        end
        read_valid = 1'b1; read_data = 32'hA5A50001;
        @(negedge clk_i);
        chk("abort_read_ack", 32'(read_ack), 32'd1);
        step();
        read_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            if (ack_o) ack_seen++;
            step();
        end
        chk("abort_no_ack", ack_seen, 0);
        last_rd = 32'hA5A50001;
        chk("abort_dat_o", dat_o, last_rd);
        run_txn(1'b0, 30'h9, 4'h3, 32'h0, 0, 2, 32'h0BADF00D);

`ifdef WB_REQ_TIMEOUT_EN
        // Read that never gets data: ERR after 16 RWAIT cycles (cycle 18)
        begin
            int err_cyc = -1;
            int rq = 0;
            ack_seen = 0;
            cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; adr_i = 30'h77; req_ready = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk_i);
                if (ack_o) ack_seen++;
                if (err_o && err_cyc < 0) begin
                    err_cyc = c;
                    chk("timeout_dat_o", dat_o, 32'hDEADBEEF);
                end
                step();
                if (err_cyc >= 0) break;
            end
            cyc_i = 1'b0; stb_i = 1'b0; req_ready = 1'b0;
            chk("timeout_err_cycle", err_cyc, 18);
            chk("timeout_no_ack", ack_seen, 0);
            @(negedge clk_i);
            chk("timeout_err_single", 32'(err_o), 32'd0);
            step();
            // New cycle must wait while the stale beat is outstanding
            cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; req_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk_i);
                if (req_valid) rq++;
                step();
            end
            cyc_i = 1'b0; stb_i = 1'b0; req_ready = 1'b0;
            chk("stale_blocks", rq, 0);
            read_valid = 1'b1; read_data = 32'h11112222;
            @(negedge clk_i);
            chk("stale_read_ack", 32'(read_ack), 32'd1);
            step();
            read_valid = 1'b0;
            last_rd = 32'hDEADBEEF;
            @(negedge clk_i);
            chk("stale_discarded", dat_o, last_rd);
            step();
            run_txn(1'b0, 30'h78, 4'hF, 32'h0, 1, 3, 32'h600DF00D);
        end
`endif

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            logic       we  = 1'($urandom);
            logic [3:0] sel = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
            idle_cycles($urandom_range(0, 2));
            run_txn(we, 30'($urandom), sel, $urandom, $urandom_range(0, 3),
                    $urandom_range(1, 4), $urandom);
        end

        // Reset asserted while a request is pending, between clock edges
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = 4'hC; adr_i = 30'h3FF;
        dat_i = 32'hFFFF0000; req_ready = 1'b0;
        step();
        @(negedge clk_i);
        chk("pre_rst_req_valid", 32'(req_valid), 32'd1);
        chk("pre_rst_req_addr", req_addr, 32'h00000FFC);
        #2 rst_i = 1'b0;
        #1;
        chk("midrst_req_valid", 32'(req_valid), 32'd0);
        chk("midrst_req_addr", req_addr, 32'd0);
        chk("midrst_req_mask", 32'(req_mask), 32'd0);
        chk("midrst_req_we", 32'(req_we), 32'd0);
        chk("midrst_write_data", write_data, 32'd0);
        chk("midrst_dat_o", dat_o, 32'd0);
        chk("midrst_ack", 32'(ack_o), 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk_i) rst_i = 1'b1;
        step();
        last_rd = 32'h0;
        idle_cycles(2);
        run_txn(1'b0, 30'h4, 4'hF, 32'h0, 0, 1, 32'h87654321);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_wb_req_bridge
